// File: rtl/spi_frame_master.sv
// spi_frame_master
// SPI initiator (mode 1: CPOL=0, CPHA=1, MSB first) that sends one fixed-width
// frame per accepted request and captures the MISO response. MOSI changes on
// the SCLK rising edge. MISO is sampled in the cycle where SCLK falls.
//
// Parameters
//   MSB     frame width in bits (2..32)
//   CLKDIV  clk cycles per SCLK half-period (>= 1)
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         frame request, only looked at while busy = 0
//   tx_data       frame to send, latched when start is accepted
//   use_special   latched when start is accepted; drives special_n with cs_n
//   busy          high from the accepted start to the end of the gap after cs_n rises
//   done          one-cycle pulse when rx_data updates
//   rx_data       captured MISO bits, first-received bit in the MSB
//   sclk, cs_n, special_n, mosi, miso   SPI port
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | waiting for start, busy = 0
// S_SETUP    | cs_n low, sclk low, CS-to-first-edge setup time
// S_SHIFT_HI | sclk high, mosi carries the current bit
// S_SHIFT_LO | sclk low, MISO bit captured when this state is entered
// S_HOLD     | cs_n low, sclk low, CS hold time after the last fall
// S_GAP      | cs_n high, busy still 1, minimum time between frames
`timescale 1ns/1ps
module spi_frame_master #(
    parameter int MSB    = 16,
    parameter int CLKDIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [MSB-1:0] tx_data,
    input  logic           use_special,
    output logic           busy,
    output logic           done,
    output logic [MSB-1:0] rx_data,
    output logic           sclk,
    output logic           cs_n,
    output logic           special_n,
    output logic           mosi,
    input  logic           miso
);

    localparam int TW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CW = $clog2(MSB + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(CLKDIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(MSB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD,
        S_GAP
    } state_t;

    state_t         r_state;
    logic [TW-1:0]  r_tmr;
    logic [CW-1:0]  r_bit_cnt;
    logic [MSB-1:0] r_tx;
    logic [MSB-1:0] r_rx;
    logic           w_tmr_done;

    // Every state lasts exactly CLKDIV cycles. The timer is loaded with CLKDIV-1
    // on state entry and the state exits when it reaches zero.
    assign w_tmr_done = (r_tmr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            special_n <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SETUP;
                        r_tmr     <= TMR_LOAD;
                        r_tx      <= tx_data;
                        r_rx      <= '0;
                        r_bit_cnt <= '0;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        // special_n tracks cs_n for the whole frame, so the
                        // latched use_special flag is kept here as its level.
                        special_n <= ~use_special;
                    end
                end
                S_SETUP: begin
                    if (w_tmr_done) begin
                        r_state <= S_SHIFT_HI;
                        r_tmr   <= TMR_LOAD;
                        sclk    <= 1'b1;
                        mosi    <= r_tx[MSB-1];
                        r_tx    <= {r_tx[MSB-2:0], 1'b0};
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (w_tmr_done) begin
                        r_state   <= S_SHIFT_LO;
                        r_tmr     <= TMR_LOAD;
                        sclk      <= 1'b0;
                        r_rx      <= {r_rx[MSB-2:0], miso};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                S_SHIFT_LO: begin
                    if (w_tmr_done) begin
                        r_tmr <= TMR_LOAD;
                        if (r_bit_cnt < BIT_LAST) begin
                            r_state <= S_SHIFT_HI;
                            sclk    <= 1'b1;
                            mosi    <= r_tx[MSB-1];
                            r_tx    <= {r_tx[MSB-2:0], 1'b0};
                        end else begin
                            // mosi keeps the last bit through HOLD
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_tmr_done) begin
                        r_state   <= S_GAP;
                        r_tmr     <= TMR_LOAD;
                        cs_n      <= 1'b1;
                        special_n <= 1'b1;
                        mosi      <= 1'b0;
                        rx_data   <= r_rx;
                        done      <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_tmr_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
`timescale 1ns/1ps
module tb_spi_frame_master;

    localparam int MA = 16;
    localparam int DA = 4;
    localparam int MB = 8;
    localparam int DB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // DUT A: default parameters
    logic          start_a = 1'b0, use_sp_a = 1'b0, miso_a = 1'b0;
    logic [MA-1:0] tx_a = '0;
    logic          busy_a, done_a, sclk_a, cs_n_a, sp_n_a, mosi_a;
    logic [MA-1:0] rx_a;

    // DUT B: fastest SCLK, 8-bit frame, MISO tied high
    logic          start_b = 1'b0, use_sp_b = 1'b0;
    logic          miso_b = 1'b1;
    logic [MB-1:0] tx_b = '0;
    logic          busy_b, done_b, sclk_b, cs_n_b, sp_n_b, mosi_b;
    logic [MB-1:0] rx_b;

    spi_frame_master #(.MSB(MA), .CLKDIV(DA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a),
        .use_special(use_sp_a), .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .special_n(sp_n_a), .mosi(mosi_a),
        .miso(miso_a)
    );

    spi_frame_master #(.MSB(MB), .CLKDIV(DB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b),
        .use_special(use_sp_b), .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .special_n(sp_n_b), .mosi(mosi_b),
        .miso(miso_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
        logic        us;
        int          t_done;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus runs 1 ns after the falling edge, after the monitors have sampled.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor / slave model A ----------------
    logic [MA-1:0] cap_a = '0, sh_a = '0, miso_word_a = '0, last_rx_a = '0, prev_rx_a = '0;
    logic          prev_sclk_a = 1'b0, prev_cs_a = 1'b1;
    int            rises_a = 0, falls_a = 0, spv_a = 0;

    always @(negedge clk) begin
        exp_t e;
        logic exp_sp;
        if (!rst_n) begin
            last_rx_a   = '0;
            prev_rx_a   = '0;
            prev_sclk_a = 1'b0;
            prev_cs_a   = 1'b1;
            miso_a      = 1'b0;
            spv_a       = 0;
            rises_a     = 0;
            falls_a     = 0;
        end else begin
            if (prev_cs_a && !cs_n_a) begin
                rises_a = 0;
                falls_a = 0;
                cap_a   = '0;
                sh_a    = miso_word_a;
            end
            if (!prev_cs_a && cs_n_a) miso_a = 1'b0;
            if (!prev_sclk_a && sclk_a) begin
                rises_a++;
                miso_a = sh_a[MA-1];
                sh_a   = {sh_a[MA-2:0], 1'b0};
            end
            if (prev_sclk_a && !sclk_a) begin
                cap_a = {cap_a[MA-2:0], mosi_a};
                falls_a++;
            end
            exp_sp = (qa.size() > 0 && qa[0].us) ? cs_n_a : 1'b1;
            if (sp_n_a !== exp_sp) spv_a++;
            if (done_a) begin
                if (qa.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
                end else begin
                    e = qa.pop_front();
                    check("a_mosi_word", 32'(cap_a), e.tx);
                    check("a_rx_data", 32'(rx_a), e.rx);
                    check("a_rx_hold", 32'(prev_rx_a), 32'(last_rx_a));
                    check("a_done_time", 32'(cyc + 1), 32'(e.t_done));
                    check("a_sclk_rises", 32'(rises_a), 32'(MA));
                    check("a_sclk_falls", 32'(falls_a), 32'(MA));
                    check("a_special_n", 32'(spv_a), 32'd0);
                    last_rx_a = e.rx[MA-1:0];
                end
                spv_a = 0;
            end
            prev_rx_a   = rx_a;
            prev_sclk_a = sclk_a;
            prev_cs_a   = cs_n_a;
        end
    end

    // ---------------- monitor / slave model B ----------------
    logic [MB-1:0] cap_b = '0;
    logic          prev_sclk_b = 1'b0, prev_cs_b = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_sclk_b = 1'b0;
            prev_cs_b   = 1'b1;
        end else begin
            if (prev_cs_b && !cs_n_b) cap_b = '0;
            if (prev_sclk_b && !sclk_b) cap_b = {cap_b[MB-2:0], mosi_b};
            if (done_b) begin
                if (qb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
                end else begin
                    e = qb.pop_front();
                    check("b_mosi_word", 32'(cap_b), e.tx);
                    check("b_rx_data", 32'(rx_b), e.rx);
                    check("b_done_time", 32'(cyc + 1), 32'(e.t_done));
                    check("b_special_n", 32'(sp_n_b), 32'd1);
                end
            end
            prev_sclk_b = sclk_b;
            prev_cs_b   = cs_n_b;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go_a(input logic [MA-1:0] tx, input logic us, input logic [MA-1:0] mw,
                        input bit push, output int t);
        exp_t e;
        step();
        tx_a        = tx;
        use_sp_a    = us;
        miso_word_a = mw;
        start_a     = 1'b1;
        t           = cyc + 1;
        if (push) begin
            e.tx     = 32'(tx);
            e.rx     = 32'(mw);
            e.us     = us;
            e.t_done = t + 1 + DA * (2 * MA + 2);
            qa.push_back(e);
        end
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int t);
        int n;
        n = 0;
        while (busy_a && n < 1000) begin
            step();
            n++;
        end
        if (busy_a) begin
            tests++;
            fails++;
            $display("FAIL a_busy_timeout: got busy=1, expected 0 within 1000 cycles");
        end else begin
            check("a_busy_fall_time", 32'(cyc + 1), 32'(t + 1 + DA * (2 * MA + 3)));
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_cs_n"}, 32'(cs_n_a), 32'd1);
        check({tag, "_special_n"}, 32'(sp_n_a), 32'd1);
        check({tag, "_sclk"}, 32'(sclk_a), 32'd0);
        check({tag, "_mosi"}, 32'(mosi_a), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_a), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int t2;
        int gap;
        int n;
        logic [15:0] pat;
        exp_t e;

        repeat (3) step();
        check_reset_a("a_rst");
        check("b_rst_cs_n", 32'(cs_n_b), 32'd1);
        check("b_rst_rx_data", 32'(rx_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Write frame with special select
        go_a(16'h0705, 1'b1, 16'h0000, 1'b1, t);
        check("a_cs_fall_t1", 32'(cs_n_a), 32'd0);
        check("a_busy_rise_t1", 32'(busy_a), 32'd1);
        wait_idle_a(t);

        // Readback of 16'hFF00 from the MISO model
        go_a(16'h0000, 1'b0, 16'hFF00, 1'b1, t);
        wait_idle_a(t);

        // Busy rejection: second request at T+50 must be dropped
        go_a(16'hAAAA, 1'b0, 16'h0000, 1'b1, t);
        while (cyc + 1 < t + 50) step();
        tx_a    = 16'h5555;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_idle_a(t);
        repeat (10) step();
        check("a_reject_cs_n", 32'(cs_n_a), 32'd1);
        check("a_reject_busy", 32'(busy_a), 32'd0);
        check("a_reject_pending", 32'(qa.size()), 32'd0);

        // Reset after the 7th SCLK fall aborts the frame without done
        go_a(16'h5A5A, 1'b0, 16'h0000, 1'b0, t);
        n = 0;
        while (falls_a < 7 && n < 500) begin
            step();
            n++;
        end
        check("a_seven_falls", 32'(falls_a), 32'd7);
        rst_n = 1'b0;
        #1;
        check_reset_a("a_midrst");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        go_a(16'h1234, 1'b1, 16'h3C5A, 1'b1, t);
        wait_idle_a(t);

        // Back-to-back frames with start held high; tx_data changes mid-frame
        step();
        tx_a        = 16'h0F0F;
        use_sp_a    = 1'b0;
        miso_word_a = 16'h0000;
        start_a     = 1'b1;
        t           = cyc + 1;
        e.tx = 32'h0F0F; e.rx = 32'h0; e.us = 1'b0; e.t_done = t + 1 + DA * (2 * MA + 2);
        qa.push_back(e);
        t2 = t + DA * (2 * MA + 3) + 1;
        e.tx = 32'hC3C3; e.rx = 32'h0; e.us = 1'b0; e.t_done = t2 + 1 + DA * (2 * MA + 2);
        qa.push_back(e);
        step();
        tx_a = 16'hC3C3;
        gap  = 0;
        while (cyc < t2) begin
            step();
            if (cs_n_a) gap++;
        end
        start_a = 1'b0;
        check("a_b2b_gap_ge_clkdiv", 32'(gap >= DA), 32'd1);
        check("a_b2b_second_cs", 32'(cs_n_a), 32'd0);
        wait_idle_a(t2);

        // Corner: CLKDIV=1, MSB=8, tx 8'h81, MISO tied high
        step();
        tx_b    = 8'h81;
        start_b = 1'b1;
        t       = cyc + 1;
        e.tx = 32'h81; e.rx = 32'hFF; e.us = 1'b0; e.t_done = t + 1 + DB * (2 * MB + 2);
        qb.push_back(e);
        step();
        start_b = 1'b0;
        pat = '0;
        while (cyc + 1 < t + 2) step();
        for (int i = 0; i < 16; i++) begin
            pat = {pat[14:0], sclk_b};
            step();
        end
        check("b_sclk_toggle", 32'(pat), 32'hAAAA);
        n = 0;
        while (busy_b && n < 100) begin
            step();
            n++;
        end
        check("b_busy_fall_time", 32'(cyc + 1), 32'(t + 1 + DB * (2 * MB + 3)));

        repeat (20) step();
        check("a_pending_end", 32'(qa.size()), 32'd0);
        check("b_pending_end", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
